fpu_int2fp_pipe: RTL and testbench

Pipelined, parametrised integer-to-binary32 converter for the FPU (FCVT.S.W/WU/L/LU class), sitting between the FPU operand mux and the FPU result arbiter. It supports signed or unsigned input per operation and all five RISC-V rounding modes, and reports the inexact flag. It uses a valid/ready handshake with full backpressure, a 2-cycle latency and a throughput of one result per cycle. It also carries a caller-defined tag through the pipeline.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fpu_lzc.sv | 27 ++
 rtl/fpu_int2fp_pipe.sv | 160 ++++++++++++++++
 tb/tb_fpu_int2fp_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: RISC-V rounding-mode encoding and binary32 field widths.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    localparam int unsigned FP32_BIAS   = 127;
    localparam int unsigned FP32_MANT_W = 23;
    localparam int unsigned FP32_EXP_W  = 8;

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; cnt_o is only meaningful when all_zero_o is 0.
module fpu_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     all_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic found;

    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && in_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

    assign all_zero_o = ~|in_i;

endmodule

// File: rtl/fpu_int2fp_pipe.sv
// Two-stage integer to binary32 converter: stage 1 takes magnitude and leading zeros,
// stage 2 normalises, rounds and registers the result.
module fpu_int2fp_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 32,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [INT_WIDTH-1:0] int_i,
    input  logic                 unsigned_i,
    input  logic [2:0]           rm_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          fp_o,
    output logic                 nx_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int unsigned LZ_W  = $clog2(INT_WIDTH);
    localparam int unsigned PAD   = FP32_MANT_W + 2;
    localparam int unsigned EXT_W = INT_WIDTH + PAD;
    localparam int unsigned G_POS = EXT_W - 2 - FP32_MANT_W;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a held result keeps its data stable until taken.
    logic adv1, adv2, accept;

    logic                 s1_valid_q;
    logic                 s1_sign_q, s1_zero_q;
    logic [INT_WIDTH-1:0] s1_mag_q;
    logic [LZ_W-1:0]      s1_lz_q;
    logic [2:0]           s1_rm_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    logic                 s2_valid_q;
    logic [31:0]          fp_q;
    logic                 nx_q;
    logic [TAG_WIDTH-1:0] tag_q;

    assign adv2       = ~s2_valid_q | out_ready_i;
    assign adv1       = ~s1_valid_q | adv2;
    assign in_ready_o = adv1;
    assign accept     = in_valid_i & adv1;

    // Stage 1: sign/magnitude split, the signed minimum wraps to 2^(INT_WIDTH-1)
    logic                 s1_sign_d;
    logic [INT_WIDTH-1:0] s1_mag_d;
    logic [LZ_W-1:0]      s1_lz_d;
    logic                 s1_zero_d;

    assign s1_sign_d = ~unsigned_i & int_i[INT_WIDTH-1];
    assign s1_mag_d  = s1_sign_d ? (-int_i) : int_i;

    fpu_lzc #(
        .WIDTH(INT_WIDTH)
    ) u_lzc (
        .in_i      (s1_mag_d),
        .cnt_o     (s1_lz_d),
        .all_zero_o(s1_zero_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b1;
            s1_mag_q   <= '0;
            s1_lz_q    <= '0;
            s1_rm_q    <= 3'b000;
            s1_tag_q   <= '0;
        end else begin
            if (flush_i) begin
                s1_valid_q <= 1'b0;
            end else if (adv1) begin
                s1_valid_q <= accept;
            end
            if (accept) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_mag_q  <= s1_mag_d;
                s1_lz_q   <= s1_lz_d;
                s1_rm_q   <= rm_i;
                s1_tag_q  <= tag_i;
            end
        end
    end

    // Stage 2: the zero pad keeps the field slices legal for narrow INT_WIDTH
    logic [INT_WIDTH-1:0]   norm;
    logic [EXT_W-1:0]       ext;
    logic [FP32_MANT_W-1:0] mant;
    logic                   guard, sticky, round_up, carry;
    logic [FP32_MANT_W:0]   mant_sum;
    logic [FP32_EXP_W-1:0]  exp_base, exp_fin;
    logic [31:0]            fp_d;
    logic                   nx_d;

    assign norm   = s1_mag_q << s1_lz_q;
    assign ext    = {norm, {PAD{1'b0}}};
    assign mant   = ext[EXT_W-2 -: FP32_MANT_W];
    assign guard  = ext[G_POS];
    assign sticky = |ext[G_POS-1:0];

    always_comb begin
        round_up = 1'b0;
        case (s1_rm_q)
            RTZ:     round_up = 1'b0;
            RDN:     round_up = (guard | sticky) & s1_sign_q;
            RUP:     round_up = (guard | sticky) & ~s1_sign_q;
            RMM:     round_up = guard;
            default: round_up = guard & (sticky | mant[0]);
        endcase
    end

    assign mant_sum = {1'b0, mant} + {{FP32_MANT_W{1'b0}}, round_up};
    assign carry    = mant_sum[FP32_MANT_W];
    assign exp_base = FP32_EXP_W'(FP32_BIAS + INT_WIDTH - 1) - FP32_EXP_W'(s1_lz_q);
    assign exp_fin  = exp_base + {{(FP32_EXP_W-1){1'b0}}, carry};

    always_comb begin
        fp_d = {s1_sign_q, exp_fin, mant_sum[FP32_MANT_W-1:0]};
        nx_d = guard | sticky;
        if (s1_zero_q) begin
            fp_d = 32'h0000_0000;
            nx_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            fp_q       <= '0;
            nx_q       <= 1'b0;
            tag_q      <= '0;
        end else begin
            if (flush_i) begin
                s2_valid_q <= 1'b0;
            end else if (adv2) begin
                s2_valid_q <= s1_valid_q;
            end
            if (adv2 && s1_valid_q) begin
                fp_q  <= fp_d;
                nx_q  <= nx_d;
                tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign fp_o        = fp_q;
    assign nx_o        = nx_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_fpu_int2fp_pipe.sv
// Bench for fpu_int2fp_pipe: directed cases, backpressure, flush, reset and random
// traffic for 32-bit and 64-bit instances against an arithmetic reference model.
module tb_fpu_int2fp_pipe;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        in_valid = 1'b0, in_ready, uns = 1'b0, out_valid, out_ready = 1'b1, nx;
    logic [31:0] int32 = '0, fp;
    logic [2:0]  rm = 3'b000;
    logic [3:0]  tag = '0, tag_out;

    logic        v64 = 1'b0, rdy64, u64 = 1'b0, ov64, or64 = 1'b1, nx64;
    logic [63:0] i64 = '0;
    logic [31:0] fp64;
    logic [2:0]  rm64 = 3'b000;
    logic [3:0]  tag64 = '0, to64;

    int n_vec = 0, n_err = 0, n_out = 0;
    logic rnd_rdy = 1'b0;
    logic [36:0] exp_q[$];

    fpu_int2fp_pipe #(.INT_WIDTH(32), .TAG_WIDTH(4)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .int_i(int32),
        .unsigned_i(uns), .rm_i(rm), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .fp_o(fp), .nx_o(nx), .tag_o(tag_out)
    );

    fpu_int2fp_pipe #(.INT_WIDTH(64), .TAG_WIDTH(4)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
        .in_valid_i(v64), .in_ready_o(rdy64), .int_i(i64),
        .unsigned_i(u64), .rm_i(rm64), .tag_i(tag64),
        .out_valid_o(ov64), .out_ready_i(or64),
        .fp_o(fp64), .nx_o(nx64), .tag_o(to64)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: exact value, truncate to 24 significant bits, round on the remainder
    function automatic logic [32:0] ref_conv(input logic [63:0] v, input int w,
                                             input logic un, input logic [2:0] r);
        logic [63:0] mask, m, q, rem, half;
        logic s, inc;
        int e;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v = v & mask;
        s = !un && v[w-1];
        m = s ? ((~v + 64'd1) & mask) : v;
        if (m == 64'd0) return 33'd0;
        e = 63;
        while (!m[e]) e--;
        if (e <= 23) begin
            q = m << (23 - e);
            rem = 64'd0;
            half = 64'd1;
        end else begin
            q = m >> (e - 23);
            rem = m - (q << (e - 23));
            half = 64'd1 << (e - 24);
        end
        case (r)
            3'd1:    inc = 1'b0;
            3'd2:    inc = (rem != 0) && s;
            3'd3:    inc = (rem != 0) && !s;
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && q[0]);
        endcase
        q = q + 64'(inc);
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        return {rem != 0, s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", nm, obs, expv);
        end
    endtask

    // Scoreboard for the 32-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("result", 64'({tag_out, nx, fp}), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back({tag, ref_conv(64'(int32), 32, uns, rm)});
        end
    end

    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Driver tasks
    task automatic send32(input logic [31:0] v, input logic u, input logic [2:0] r,
                          input logic [3:0] t);
        int guard;
        logic acc;
        int32 = v; uns = u; rm = r; tag = t; in_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic conv32(input logic [31:0] v, input logic u, input logic [2:0] r,
                          input logic [3:0] t, input logic [31:0] fpx, input logic nxx,
                          input string nm);
        int guard;
        out_ready = 1'b1;
        send32(v, u, r, t);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 10);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_fp"}, 64'(fp), 64'(fpx));
        chk({nm, "_nx"}, 64'(nx), 64'(nxx));
        @(posedge clk);
        #1;
    endtask

    task automatic lat32(input logic [31:0] v, input logic [3:0] t, input string nm);
        out_ready = 1'b1;
        send32(v, 1'b0, RNE, t);
        @(negedge clk);
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic conv64(input logic [63:0] v, input logic u, input logic [2:0] r,
                          input logic [3:0] t, input logic [32:0] expv, input string nm);
        int guard;
        logic acc;
        i64 = v; u64 = u; rm64 = r; tag64 = t; v64 = 1'b1; or64 = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            acc = rdy64;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        v64 = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!ov64 && guard < 10);
        chk({nm, "_valid"}, 64'(ov64), 64'd1);
        chk({nm, "_res"}, 64'({nx64, fp64}), 64'(expv));
        chk({nm, "_tag"}, 64'(to64), 64'(t));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sw_exp[5] = '{32'h4B80_0000, 32'h4B80_0000, 32'h4B80_0000,
                               32'h4B80_0001, 32'h4B80_0001};
    logic [31:0] bp_v[5];
    logic [63:0] r64;
    int n0;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fp", 64'(fp), 64'd0);
        chk("rst_nx", 64'(nx), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid64", 64'(ov64), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed values
        conv32(32'h0000_0001, 1'b0, RNE, 4'd1, 32'h3F80_0000, 1'b0, "one");
        conv32(32'hFFFF_FFFF, 1'b0, RNE, 4'd2, 32'hBF80_0000, 1'b0, "neg_one");
        conv32(32'h8000_0000, 1'b0, RNE, 4'd3, 32'hCF00_0000, 1'b0, "int_min");
        conv32(32'h0000_0000, 1'b0, RDN, 4'd4, 32'h0000_0000, 1'b0, "zero_s");
        conv32(32'h0000_0000, 1'b1, RUP, 4'd5, 32'h0000_0000, 1'b0, "zero_u");
        for (int r = 0; r < 5; r++)
            conv32(32'h0100_0001, 1'b0, 3'(r), 4'(r), sw_exp[r], 1'b1,
                   $sformatf("sweep_rm%0d", r));
        conv32(32'hFEFF_FFFF, 1'b0, RDN, 4'd6, 32'hCB80_0001, 1'b1, "neg_rdn");
        conv32(32'hFFFF_FFFF, 1'b1, RNE, 4'd7, 32'h4F80_0000, 1'b1, "umax_rne");
        conv32(32'hFFFF_FFFF, 1'b1, RTZ, 4'd8, 32'h4F7F_FFFF, 1'b1, "umax_rtz");
        conv32(32'h01FF_FFFF, 1'b0, RNE, 4'd9, 32'h4C00_0000, 1'b1, "mant_carry");
        conv32(32'h0100_0003, 1'b0, 3'b111, 4'd10, 32'h4B80_0002, 1'b1, "rm111_rne");
        conv64(64'h8000_0000_0000_0000, 1'b1, RNE, 4'd1, {1'b0, 32'h5F00_0000}, "u64_top");
        conv64(64'h8000_0000_0000_0000, 1'b0, RNE, 4'd2, {1'b0, 32'hDF00_0000}, "s64_min");
        lat32(32'd1000, 4'd11, "lat_idle");

        // Backpressure: out_ready low for three cycles while five operands queue up
        for (int i = 0; i < 5; i++) bp_v[i] = $urandom;
        n0 = n_out;
        out_ready = 1'b0;
        uns = 1'b0; rm = RNE; in_valid = 1'b1;
        int32 = bp_v[0]; tag = 4'd1;
        @(negedge clk); chk("bp_rdy0", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        int32 = bp_v[1]; tag = 4'd2;
        @(negedge clk); chk("bp_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        int32 = bp_v[2]; tag = 4'd3;
        @(negedge clk);
        chk("bp_rdy2", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send32(bp_v[i], 1'b0, RNE, 4'(i + 1));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_count", 64'(n_out - n0), 64'd5);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Flush with both stages full and an accept in the same cycle
        out_ready = 1'b0;
        send32(32'h1234_5678, 1'b0, RNE, 4'd6);
        send32(32'h8765_4321, 1'b1, RUP, 4'd7);
        int32 = 32'h0000_0042; tag = 4'd8; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk); chk("fl_full", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("fl_killed1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("fl_killed2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        lat32(32'h0000_0777, 4'd9, "lat_flush");

        // Asynchronous reset mid-stream
        send32(32'h00AB_CDEF, 1'b0, RNE, 4'd10);
        send32(32'hFF00_0001, 1'b0, RDN, 4'd11);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_fp", 64'({tag_out, nx, fp}), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk); chk("mrst_killed1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("mrst_killed2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        lat32(32'h0000_0123, 4'd12, "lat_reset");

        // Random traffic with random backpressure
        rnd_rdy = 1'b1;
        repeat (300)
            send32($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        repeat (40) begin
            r64 = {$urandom, $urandom} >> $urandom_range(0, 63);
            u64 = 1'($urandom_range(0, 1));
            rm64 = 3'($urandom_range(0, 7));
            conv64(r64, u64, rm64, 4'($urandom_range(0, 15)), ref_conv(r64, 64, u64, rm64), "rnd64");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
